// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Debug read-out engine for the 32x32 register file. A Start pulse walks
//   the register indices in ascending order over one asynchronous read port.
//   Each word is captured and offered as an {index, data} beat on a
//   valid/ready stream. A one-cycle Done pulse follows the last accepted beat.
//
// Parameters
//   NREGS    number of registers walked (indices 0..NREGS-1, NREGS <= 32)
//   SKIP_X0  when non-zero the walk starts at index 1 (x0 is hardwired zero)
//
// Ports
//   CLK       clock, all state updates on posedge
//   RST       synchronous active-high reset
//   Start     begin a dump (only honoured in IDLE)
//   Abort     cancel a dump in progress
//   RdAddr    register-file read address (decoded from state/ptr)
//   RdData    asynchronous read data for RdAddr
//   OutValid  output beat valid
//   OutReady  sink accepts the beat
//   OutIdx    register index of the current beat
//   OutData   register contents of the current beat
//   Busy      high in every non-IDLE state
//   Done      one-cycle pulse after the last beat is accepted
module reg_dump_unit #(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned SKIP_X0 = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        Abort,
  output logic [4:0]  RdAddr,
  input  logic [31:0] RdData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [4:0]  OutIdx,
  output logic [31:0] OutData,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [4:0] LAST  = 5'(NREGS - 1);
  localparam logic [4:0] FIRST = (SKIP_X0 != 0) ? 5'd1 : 5'd0;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] ptr;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; Abort wins over a same-cycle handshake
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Start && !Abort) state_nxt = READ;
      READ: state_nxt = Abort ? IDLE : SEND;
      SEND: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else if (OutReady) begin
          state_nxt = (ptr == LAST) ? FIN : READ;
        end
      end
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer and captured beat. Termination is by the compare against LAST,
  // so ptr is never advanced past it and never relies on 5-bit wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr     <= '0;
      OutIdx  <= '0;
      OutData <= '0;
    end else begin
      unique case (state)
        IDLE: if (Start && !Abort) ptr <= FIRST;
        READ: begin
          if (!Abort) begin
            OutIdx  <= ptr;
            OutData <= RdData;
          end
        end
        SEND: if (!Abort && OutReady && ptr != LAST) ptr <= ptr + 5'd1;
        default: ;
      endcase
    end
  end

  // Output decode from the state register
  always_comb begin
    RdAddr   = (state == READ) ? ptr : '0;
    OutValid = (state == SEND);
    Busy     = (state != IDLE);
    Done     = (state == FIN);
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit
//   Self-checking bench for reg_dump_unit. Two instances share the control
//   inputs: dut0 walks from x0, dut1 skips x0. Each instance reads its own
//   port of a bench-side register file model.
module tb_reg_dump_unit;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] BASE = 32'hA5A50000;
  localparam logic [31:0] BEEF = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        OutReady = 1'b0;

  logic [4:0]  rd0, rd1, idx0, idx1;
  logic [31:0] rdd0, rdd1, data0, data1;
  logic        valid0, valid1, busy0, busy1, done0, done1;

  logic [31:0] rf [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    rdd0 = rf[rd0];
    rdd1 = rf[rd1];
  end

  reg_dump_unit #(.NREGS(32), .SKIP_X0(0)) dut0 (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .RdAddr(rd0), .RdData(rdd0), .OutValid(valid0), .OutReady(OutReady),
    .OutIdx(idx0), .OutData(data0), .Busy(busy0), .Done(done0)
  );

  reg_dump_unit #(.NREGS(32), .SKIP_X0(1)) dut1 (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .RdAddr(rd1), .RdData(rdd1), .OutValid(valid1), .OutReady(OutReady),
    .OutIdx(idx1), .OutData(data1), .Busy(busy1), .Done(done1)
  );

  typedef struct {
    logic        start, abort, ready;
    logic        busy, valid, done;
    logic [4:0]  rdaddr, idx;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic r,
                              input logic b, input logic v, input logic d,
                              input logic [4:0] ra, input logic [4:0] ix,
                              input logic [31:0] dt);
    vec_t t;
    t.start = s; t.abort = a; t.ready = r;
    t.busy = b; t.valid = v; t.done = d;
    t.rdaddr = ra; t.idx = ix; t.data = dt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_rf();
    for (int i = 0; i < 32; i++) rf[i] = BASE + 32'(i);
  endtask

  function automatic logic [31:0] expd(input int i, input bit poked);
    if (poked && i == 20) return BEEF;
    return BASE + 32'(i);
  endfunction

  // Full dump on both instances; bp = random backpressure, poke = write
  // reg 20 while dut0 reads index 3. Start is re-pulsed mid-dump.
  task automatic run_dump(input bit bp, input bit poke);
    int next0, next1, d0cnt, d1cnt;
    bit finished, stall0;
    logic [4:0] pidx0;
    logic [31:0] pdata0;
    next0 = 0; next1 = 1; d0cnt = 0; d1cnt = 0;
    finished = 0; stall0 = 0; pidx0 = '0; pdata0 = '0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 400 && !finished; c++) begin
      OutReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      Start = (c == 10) ? 1'b1 : 1'b0;
      if (poke && rd0 == 5'd3 && busy0 && !valid0) rf[20] = BEEF;
      if (!bp && c == 1) begin
        chk("first_busy0", 32'(busy0), 32'd1);
        chk("first_rdaddr0", 32'(rd0), 32'd0);
        chk("first_rdaddr1", 32'(rd1), 32'd1);
      end
      if (!bp && c == 2) chk("first_valid0", 32'(valid0), 32'd1);
      if (stall0) begin
        chk("hold_valid0", 32'(valid0), 32'd1);
        chk("hold_idx0", 32'(idx0), 32'(pidx0));
        chk("hold_data0", data0, pdata0);
      end
      stall0 = valid0 && !OutReady;
      pidx0 = idx0;
      pdata0 = data0;
      if (valid0 && OutReady) begin
        chk("beat_idx0", 32'(idx0), 32'(next0));
        chk("beat_data0", data0, expd(next0, poke));
        next0++;
      end
      if (valid1 && OutReady) begin
        chk("beat_idx1", 32'(idx1), 32'(next1));
        chk("beat_data1", data1, expd(next1, poke));
        next1++;
      end
      if (done0) begin
        d0cnt++;
        chk("done_beats0", 32'(next0), 32'd32);
        if (!bp) chk("done_cycle0", 32'(c), 32'd65);
      end
      if (done1) begin
        d1cnt++;
        chk("done_beats1", 32'(next1 - 1), 32'd31);
        if (!bp) chk("done_cycle1", 32'(c), 32'd63);
      end
      if (!bp && c == 66) chk("busy_fall0", 32'(busy0), 32'd0);
      if (d0cnt > 0 && d1cnt > 0 && !busy0 && !busy1) finished = 1;
      tick();
    end
    Start = 1'b0;
    OutReady = 1'b0;
    chk("done_once0", 32'(d0cnt), 32'd1);
    chk("done_once1", 32'(d1cnt), 32'd1);
  endtask

  vec_t vecs [11];

  initial begin
    fill_rf();

    // Abort/restart sequence on dut0, one record per clock
    vecs[0]  = mk(H, H, L,  L, L, L,  5'd0, 5'd0, 32'h0);
    vecs[1]  = mk(H, L, L,  H, L, L,  5'd0, 5'd0, 32'h0);
    vecs[2]  = mk(L, L, L,  H, H, L,  5'd0, 5'd0, BASE);
    vecs[3]  = mk(L, L, L,  H, H, L,  5'd0, 5'd0, BASE);
    vecs[4]  = mk(L, L, H,  H, L, L,  5'd1, 5'd0, BASE);
    vecs[5]  = mk(H, L, H,  H, H, L,  5'd0, 5'd1, BASE + 32'd1);
    vecs[6]  = mk(L, H, H,  L, L, L,  5'd0, 5'd1, BASE + 32'd1);
    vecs[7]  = mk(H, L, L,  H, L, L,  5'd0, 5'd1, BASE + 32'd1);
    vecs[8]  = mk(L, L, L,  H, H, L,  5'd0, 5'd0, BASE);
    vecs[9]  = mk(L, H, L,  L, L, L,  5'd0, 5'd0, BASE);
    vecs[10] = mk(L, L, L,  L, L, L,  5'd0, 5'd0, BASE);

    // Reset state
    tick();
    tick();
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_idx0", 32'(idx0), 32'd0);
    chk("rst_data0", data0, 32'd0);
    chk("rst_rdaddr0", 32'(rd0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    RST = 1'b0;
    tick();

    for (int v = 0; v < 11; v++) begin
      Start = vecs[v].start;
      Abort = vecs[v].abort;
      OutReady = vecs[v].ready;
      tick();
      chk($sformatf("vec%0d_busy", v), 32'(busy0), 32'(vecs[v].busy));
      chk($sformatf("vec%0d_valid", v), 32'(valid0), 32'(vecs[v].valid));
      chk($sformatf("vec%0d_done", v), 32'(done0), 32'(vecs[v].done));
      chk($sformatf("vec%0d_rdaddr", v), 32'(rd0), 32'(vecs[v].rdaddr));
      chk($sformatf("vec%0d_idx", v), 32'(idx0), 32'(vecs[v].idx));
      chk($sformatf("vec%0d_data", v), data0, vecs[v].data);
    end
    Start = 1'b0;
    Abort = 1'b0;
    OutReady = 1'b0;
    tick();
    chk("idle_busy1", 32'(busy1), 32'd0);

    // Full dump with sink always ready, Start re-pulse and reg 20 write
    run_dump(1'b0, 1'b1);
    fill_rf();
    tick();

    // Same dump under random backpressure
    run_dump(1'b1, 1'b0);
    tick();

    // RST mid-dump at index 5, with Start held during the reset cycle
    begin
      bit hit;
      hit = 0;
      OutReady = 1'b1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
        if (valid0 && idx0 == 5'd5) hit = 1;
        else tick();
      end
      chk("rst_mid_reached", 32'(hit), 32'd1);
      RST = 1'b1;
      Start = 1'b1;
      tick();
      chk("mid_rst_busy0", 32'(busy0), 32'd0);
      chk("mid_rst_valid0", 32'(valid0), 32'd0);
      chk("mid_rst_idx0", 32'(idx0), 32'd0);
      chk("mid_rst_data0", data0, 32'd0);
      chk("mid_rst_rdaddr0", 32'(rd0), 32'd0);
      chk("mid_rst_done0", 32'(done0), 32'd0);
      chk("mid_rst_busy1", 32'(busy1), 32'd0);
      chk("mid_rst_idx1", 32'(idx1), 32'd0);
      RST = 1'b0;
      Start = 1'b0;
      tick();
      chk("rst_start_ignored", 32'(busy0), 32'd0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      chk("restart_valid0", 32'(valid0), 32'd1);
      chk("restart_idx0", 32'(idx0), 32'd0);
      chk("restart_data0", data0, BASE);
      chk("restart_idx1", 32'(idx1), 32'd1);
      OutReady = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
